instr_fetcher: RTL and testbench

Instruction fetch unit that produces the 32-bit instruction words consumed by the decoder. It issues byte reads through the memory arbiter, assembles little-endian words, and buffers them with their PC in a small FIFO. It presents the head entry to the issue stage with a valid/ready handshake. A jump redirect flushes the queue and restarts fetching at a new PC.

---
 rtl/instr_fetcher_pkg.sv | 17 +
 rtl/instr_queue.sv | 59 +++++
 rtl/instr_fetcher.sv | 129 ++++++++++++
 tb/tb_instr_fetcher.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetcher_pkg.sv
// Shared widths and the queue entry layout for the instruction fetch path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package instr_fetcher_pkg;

    localparam int InstrWidth   = 32;
    localparam int AddrWidth    = 32;
    localparam int MemDataWidth = 8;

    typedef struct packed {
        logic [AddrWidth-1:0]  pc;
        logic [InstrWidth-1:0] instr;
    } entry_t;

    localparam int EntryWidth = $bits(entry_t);

endpackage

// File: rtl/instr_queue.sv
// Synchronous FIFO of {pc, instr} entries with flush; head reads as zero when empty.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: the producer reserves a slot via count; pops of an empty queue are ignored.
module instr_queue
    import instr_fetcher_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  en,
    input  logic                  flush,
    input  logic                  push,
    input  logic [EntryWidth-1:0] push_dat,
    input  logic                  pop,
    output logic [CW-1:0]         count,
    output logic                  empty,
    output logic [EntryWidth-1:0] head_dat
);

    logic [EntryWidth-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  do_pop;

    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign head_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (en) begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (do_pop) rd_ptr <= rd_ptr + PW'(1);
                case ({push, do_pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: ;
                endcase
            end
        end
    end

    // Storage carries no reset; the head is masked by empty instead.
    always_ff @(posedge clk_in) begin
        if (rst_in && en && !flush && push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/instr_fetcher.sv
// Fetches 32-bit little-endian instruction words one byte at a time and queues them with their PC.
// Latency: 6 cycles from IDLE to valid_out with back-to-back grants; 1 word per 6 cycles.
// Backpressure: fetch starts only with a free queue slot; withheld grants stretch REQ; rdy_in low freezes all.
module instr_fetcher
    import instr_fetcher_pkg::*;
#(
    parameter int                   DEPTH    = 4,
    parameter logic [AddrWidth-1:0] RESET_PC = 32'h0
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    output logic                    mem_req_out,
    output logic [AddrWidth-1:0]    mem_a_out,
    input  logic                    mem_gnt_in,
    input  logic [MemDataWidth-1:0] mem_din,
    input  logic                    jump_in,
    input  logic [AddrWidth-1:0]    jump_pc_in,
    output logic                    valid_out,
    output logic [InstrWidth-1:0]   instr_out,
    output logic [AddrWidth-1:0]    pc_out,
    input  logic                    ready_in
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        LAST = 2'd2
    } state_t;

    state_t               state;
    logic [AddrWidth-1:0] fetch_pc;
    logic [1:0]           byte_idx;
    logic [1:0]           pend_idx;
    logic                 pend;
    logic [23:0]          asm_lo;

    logic [CW-1:0]        count;
    logic [CW-1:0]        count_after_pop;
    logic                 empty;
    logic                 pop;
    logic                 push;
    logic                 gnt;
    entry_t               head;
    entry_t               push_ent;

    assign mem_req_out     = rdy_in && (state == REQ);
    assign mem_a_out       = mem_req_out ? (fetch_pc + AddrWidth'(byte_idx)) : '0;
    assign gnt             = mem_req_out && mem_gnt_in;

    assign valid_out       = !empty;
    assign pop             = valid_out && ready_in;
    assign count_after_pop = count - CW'(pop);

    // Entering LAST happens only on the byte-3 grant, so a pending return there is byte 3.
    assign push            = (state == LAST) && pend;
    assign push_ent        = '{pc: fetch_pc, instr: {mem_din, asm_lo}};

    assign instr_out       = head.instr;
    assign pc_out          = head.pc;

    instr_queue #(.DEPTH(DEPTH)) u_queue (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .en       (rdy_in),
        .flush    (jump_in),
        .push     (push),
        .push_dat (push_ent),
        .pop      (pop),
        .count    (count),
        .empty    (empty),
        .head_dat (head)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            byte_idx <= 2'd0;
            pend_idx <= 2'd0;
            pend     <= 1'b0;
            asm_lo   <= '0;
        end else if (rdy_in) begin
            if (jump_in) begin
                state    <= IDLE;
                fetch_pc <= jump_pc_in;
                byte_idx <= 2'd0;
                pend     <= 1'b0;
            end else begin
                pend <= gnt;
                if (gnt) pend_idx <= byte_idx;

                if (pend) begin
                    case (pend_idx)
                        2'd0:    asm_lo[7:0]   <= mem_din;
                        2'd1:    asm_lo[15:8]  <= mem_din;
                        2'd2:    asm_lo[23:16] <= mem_din;
                        default: ;
                    endcase
                end

                case (state)
                    IDLE: begin
                        if (count_after_pop < CW'(DEPTH)) begin
                            state    <= REQ;
                            byte_idx <= 2'd0;
                        end
                    end
                    REQ: begin
                        if (gnt) begin
                            byte_idx <= byte_idx + 2'd1;
                            if (byte_idx == 2'd3) state <= LAST;
                        end
                    end
                    LAST: begin
                        if (pend) begin
                            fetch_pc <= fetch_pc + 32'd4;
                            state    <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_fetcher.sv
// Scoreboard bench for instr_fetcher: a byte memory plus randomised arbiter feed the DUT,
// and every popped word is checked against the sequential-PC word stream implied by the jumps.
module tb_instr_fetcher;

    localparam int DEPTH = 4;
    localparam int QLEN  = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk_in     = 1'b0;
    logic        rst_in     = 1'b0;
    logic        rdy_in     = 1'b1;
    logic        mem_req_out;
    logic [31:0] mem_a_out;
    logic        mem_gnt_in = 1'b0;
    logic [7:0]  mem_din    = 8'h00;
    logic        jump_in    = 1'b0;
    logic [31:0] jump_pc_in = 32'h0;
    logic        valid_out;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        ready_in   = 1'b0;

    logic [7:0]  mem [4096];
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] model_pc   = 32'h0;
    int          vectors    = 0;
    int          miscompares = 0;
    int          pops       = 0;
    int          pops_start = 0;
    int          grants     = 0;
    int          grant_pct  = 100;
    logic        alt_mode   = 1'b0;
    int          arb_cycle  = 0;
    logic        rdy_nxt    = 1'b1;
    logic        gnt_prev   = 1'b0;
    logic [31:0] a_prev     = 32'h0;
    logic        found;

    instr_fetcher #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .mem_req_out (mem_req_out),
        .mem_a_out   (mem_a_out),
        .mem_gnt_in  (mem_gnt_in),
        .mem_din     (mem_din),
        .jump_in     (jump_in),
        .jump_pc_in  (jump_pc_in),
        .valid_out   (valid_out),
        .instr_out   (instr_out),
        .pc_out      (pc_out),
        .ready_in    (ready_in)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] w;
        logic [31:0] ak;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            ak = a + 32'(k);
            w[8*k +: 8] = mem[ak[11:0]];
        end
        return w;
    endfunction

    // Expected stream: consecutive words from the last jump target (or reset PC).
    function automatic void refill();
        while (exp_q.size() < QLEN) begin
            exp_q.push_back('{pc: model_pc, instr: word_at(model_pc)});
            model_pc = model_pc + 32'd4;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %08h, expected %08h at %0t", name, act, expv, $time);
        end
    endtask

    // Arbiter: data returns the cycle after a grant; never grants the cycle before rdy_in drops.
    always @(posedge clk_in) begin
        #2;
        arb_cycle++;
        mem_din = gnt_prev ? mem[a_prev[11:0]] : 8'($urandom);
        mem_gnt_in = mem_req_out && rdy_nxt &&
                     (alt_mode ? (arb_cycle % 2 == 0) : ($urandom_range(99) < grant_pct));
    end

    // Monitor: pops the scoreboard on every real handshake.
    always @(negedge clk_in) begin
        if (rst_in) begin
            if (rdy_in && !jump_in && valid_out && ready_in) begin
                mon_e = exp_q.pop_front();
                check("head_pc", pc_out, mon_e.pc);
                check("head_instr", instr_out, mon_e.instr);
                pops++;
                refill();
            end
            if (!valid_out) begin
                check("empty_instr", instr_out, 32'd0);
                check("empty_pc", pc_out, 32'd0);
            end
            if (!rdy_in) check("frozen_req", 32'(mem_req_out), 32'd0);
        end
        gnt_prev = mem_req_out && mem_gnt_in;
        a_prev   = mem_a_out;
    end

    task automatic cyc(input logic rn, input logic jmp, input logic [31:0] jpc, input logic rdyc);
        @(posedge clk_in);
        #1;
        rdy_in     = rdy_nxt;
        rdy_nxt    = rn;
        jump_in    = jmp && rdy_in;
        jump_pc_in = jpc;
        ready_in   = rdyc;
        if (jump_in) begin
            exp_q.delete();
            model_pc = jpc;
            refill();
        end
    endtask

    task automatic do_reset();
        @(posedge clk_in);
        #1;
        rst_in   = 1'b0;
        rdy_in   = 1'b1;
        rdy_nxt  = 1'b1;
        jump_in  = 1'b0;
        ready_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        exp_q.delete();
        model_pc = 32'h0;
        refill();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h93; mem[1] = 8'h00; mem[2] = 8'h50; mem[3] = 8'h00;
        mem[12'h100] = 8'hb3; mem[12'h101] = 8'h05; mem[12'h102] = 8'hb5; mem[12'h103] = 8'h00;

        do_reset();
        #3;
        check("rst_req", 32'(mem_req_out), 32'd0);
        check("rst_addr", mem_a_out, 32'd0);
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_instr", instr_out, 32'd0);
        check("rst_pc", pc_out, 32'd0);

        // First word after reset: bytes 0..3 in cycles 1-4, valid in cycle 6.
        for (int c = 1; c <= 6; c++) begin
            cyc(1'b1, 1'b0, 32'h0, 1'b0);
            #3;
            if (c <= 4) begin
                check("fetch_req", 32'(mem_req_out), 32'd1);
                check("fetch_addr", mem_a_out, 32'(c - 1));
            end else if (c == 5) begin
                check("push_cycle_valid", 32'(valid_out), 32'd0);
            end else begin
                check("first_valid", 32'(valid_out), 32'd1);
                check("first_instr", instr_out, 32'h0050_0093);
                check("first_pc", pc_out, 32'd0);
            end
        end

        // Fill with no consumer: exactly four words, then quiet.
        grants = 4;
        for (int c = 7; c <= 40; c++) begin
            cyc(1'b1, 1'b0, 32'h0, 1'b0);
            #3;
            if (mem_req_out && mem_gnt_in) grants++;
        end
        check("fill_grants", grants, 32'd16);
        check("fill_req_idle", 32'(mem_req_out), 32'd0);

        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        #3;
        check("pop_cycle_req", 32'(mem_req_out), 32'd0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        #3;
        check("restart_req", 32'(mem_req_out), 32'd1);
        check("restart_addr", mem_a_out, 32'd16);

        // Pop coincides with the push of PC 16 while three entries are held.
        for (int c = 2; c <= 5; c++) cyc(1'b1, 1'b0, 32'h0, c == 5);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        #3;
        check("pushpop_req", 32'(mem_req_out), 32'd1);
        check("pushpop_addr", mem_a_out, 32'd20);
        for (int c = 0; c < 7; c++) cyc(1'b1, 1'b0, 32'h0, 1'b0);
        #3;
        check("full_again_req", 32'(mem_req_out), 32'd0);

        for (int c = 0; c < 40; c++) cyc(1'b1, 1'b0, 32'h0, 1'b1);

        // Flush right after a byte-1 grant.
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            cyc(1'b1, 1'b0, 32'h0, 1'b0);
            #3;
            if (mem_req_out && mem_gnt_in && mem_a_out[1:0] == 2'd1) found = 1'b1;
        end
        check("flush_found_b1", 32'(found), 32'd1);
        cyc(1'b1, 1'b1, 32'h100, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        #3;
        check("flush_valid", 32'(valid_out), 32'd0);
        check("flush_req_idle", 32'(mem_req_out), 32'd0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        #3;
        check("flush_req", 32'(mem_req_out), 32'd1);
        check("flush_addr", mem_a_out, 32'h100);
        for (int c = 0; c < 20; c++) cyc(1'b1, 1'b0, 32'h0, 1'b1);

        // rdy_in low for five cycles while byte 1 of PC 0x200 is outstanding.
        cyc(1'b1, 1'b1, 32'h200, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        #3;
        check("rdy_b0_addr", mem_a_out, 32'h200);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        #3;
        check("rdy_b1_addr", mem_a_out, 32'h201);
        for (int c = 0; c < 5; c++) begin
            cyc(c == 4, 1'b0, 32'h0, 1'b1);
            #3;
            check("rdy_low_req", 32'(mem_req_out), 32'd0);
            check("rdy_low_valid", 32'(valid_out), 32'd0);
        end
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        #3;
        check("rdy_resume_req", 32'(mem_req_out), 32'd1);
        check("rdy_resume_addr", mem_a_out, 32'h201);
        for (int c = 0; c < 3; c++) cyc(1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        #3;
        check("rdy_resume_valid", 32'(valid_out), 32'd1);
        check("rdy_resume_pc", pc_out, 32'h200);

        // Grants on alternate cycles only.
        alt_mode = 1'b1;
        for (int c = 0; c < 80; c++) cyc(1'b1, 1'b0, 32'h0, 1'b1);
        alt_mode = 1'b0;

        // Randomised traffic: grant stalls, consumer stalls, freezes, jumps incl. PC wrap.
        grant_pct  = 60;
        pops_start = pops;
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] jpc;
            jpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(15)))
                                           : 32'($urandom_range(4095));
            cyc($urandom_range(99) < 90, $urandom_range(199) < 3, jpc, $urandom_range(1) == 1);
        end
        check("random_progress", 32'((pops - pops_start) >= 50), 32'd1);

        grant_pct = 100;
        for (int c = 0; c < 40; c++) cyc(1'b1, 1'b0, 32'h0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
